// File: rtl/mii_base_r_encoder_if.sv
// MII-to-BASE-R encoder bus: the MII word going in and the encoded block going out.
// The master drives MII words and observes blocks; the slave is the encoder.
interface mii_base_r_encoder_if #(
    parameter int ERR_CNT_W = 16
);
    logic                 i_valid;
    logic [63:0]          i_txd;
    logic [7:0]           i_txc;
    logic                 o_valid;
    logic [65:0]          o_tx_block;
    logic [ERR_CNT_W-1:0] o_err_cnt;

    modport master (
        output i_valid, i_txd, i_txc,
        input  o_valid, o_tx_block, o_err_cnt
    );

    modport slave (
        input  i_valid, i_txd, i_txc,
        output o_valid, o_tx_block, o_err_cnt
    );
endinterface

// File: rtl/mii_base_r_encoder.sv
// 64b/66b BASE-R transmit encoder.
// Classifies each MII word as D, C, S, T or E, runs the transmit state machine
// and registers one 66-bit block per accepted word (1-cycle latency).
// Build option: define LANE4_START_EN to accept a lane-4 start word (type 0x33);
// without it that word encodes as an error block.
module mii_base_r_encoder #(
    parameter int         ERR_CNT_W  = 16,
    parameter logic [7:0] IDLE_CODE  = 8'h07,
    parameter logic [7:0] START_CODE = 8'hFB,
    parameter logic [7:0] EOF_CODE   = 8'hFD,
    parameter logic [7:0] ERROR_CODE = 8'hFE
) (
    input logic                 clk,
    input logic                 i_rst,
    mii_base_r_encoder_if.slave bus
);

    localparam logic [2:0] TX_INIT = 3'd0;
    localparam logic [2:0] TX_C    = 3'd1;
    localparam logic [2:0] TX_D    = 3'd2;
    localparam logic [2:0] TX_T    = 3'd3;
    localparam logic [2:0] TX_E    = 3'd4;

    localparam logic [2:0] CLS_D = 3'd0;
    localparam logic [2:0] CLS_C = 3'd1;
    localparam logic [2:0] CLS_S = 3'd2;
    localparam logic [2:0] CLS_T = 3'd3;
    localparam logic [2:0] CLS_E = 3'd4;

    localparam logic [7:0]  BT_C         = 8'h1E;
    localparam logic [65:0] IDLE_BLOCK   = {56'h0, BT_C, 2'b10};
    localparam logic [65:0] ERROR_BLOCK  = {{8{7'h1E}}, BT_C, 2'b10};

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic [2:0]           cls;
    logic                 emit_err;
    logic [7:0]           lane_ctl_ok;
    logic [55:0]          ctl_codes;
    logic [7:0]           ctl_type;
    logic [55:0]          ctl_payload;
    logic                 tail_idle;
    logic [7:0]           t_mask;
    logic [65:0]          block_nxt;
    logic                 valid_q;
    logic [65:0]          block_q;
    logic [ERR_CNT_W-1:0] err_cnt;

    // Block type for a terminate in lane k.
    function automatic logic [7:0] t_type(input int k);
        case (k)
            0:       t_type = 8'h87;
            1:       t_type = 8'h99;
            2:       t_type = 8'hAA;
            3:       t_type = 8'hB4;
            4:       t_type = 8'hCC;
            5:       t_type = 8'hD2;
            6:       t_type = 8'hE1;
            default: t_type = 8'hFF;
        endcase
    endfunction

    // Translate each lane into its 7-bit control code and flag lanes that are idle/error.
    always_comb begin
        lane_ctl_ok = '0;
        ctl_codes   = '0;
        for (int k = 0; k < 8; k++) begin
            if (bus.i_txd[8*k +: 8] == IDLE_CODE) begin
                lane_ctl_ok[k]      = 1'b1;
                ctl_codes[7*k +: 7] = 7'h00;
            end else if (bus.i_txd[8*k +: 8] == ERROR_CODE) begin
                lane_ctl_ok[k]      = 1'b1;
                ctl_codes[7*k +: 7] = 7'h1E;
            end
        end
    end

    // Classify the word and build the control-block type and payload.
    always_comb begin
        cls         = CLS_E;
        ctl_type    = BT_C;
        ctl_payload = '0;
        tail_idle   = 1'b0;
        t_mask      = '0;
        if (bus.i_txc == 8'h00) begin
            cls = CLS_D;
        end else if (bus.i_txc == 8'hFF && (&lane_ctl_ok)) begin
            cls         = CLS_C;
            ctl_payload = ctl_codes;
        end else if (bus.i_txc == 8'h01 && bus.i_txd[7:0] == START_CODE) begin
            cls         = CLS_S;
            ctl_type    = 8'h78;
            ctl_payload = bus.i_txd[63:8];
        end
`ifdef LANE4_START_EN
        else if (bus.i_txc == 8'h1F && bus.i_txd[39:32] == START_CODE && (&lane_ctl_ok[3:0])) begin
            cls         = CLS_S;
            ctl_type    = 8'h33;
            ctl_payload = {bus.i_txd[63:40], 4'h0, ctl_codes[27:0]};
        end
`endif
        else begin
            for (int k = 0; k < 8; k++) begin
                t_mask    = 8'hFF << k;
                tail_idle = 1'b1;
                for (int j = k + 1; j < 8; j++) begin
                    if (bus.i_txd[8*j +: 8] != IDLE_CODE) begin
                        tail_idle = 1'b0;
                    end
                end
                if (bus.i_txc == t_mask && bus.i_txd[8*k +: 8] == EOF_CODE && tail_idle) begin
                    cls      = CLS_T;
                    ctl_type = t_type(k);
                    for (int j = 0; j < k; j++) begin
                        ctl_payload[8*j +: 8] = bus.i_txd[8*j +: 8];
                    end
                end
            end
        end
    end

    // Transmit state machine: any class not legal in the current state becomes an E block.
    always_comb begin
        state_nxt = TX_E;
        emit_err  = 1'b1;
        case (state)
            TX_INIT, TX_C, TX_T: begin
                if (cls == CLS_C) begin
                    state_nxt = TX_C;
                    emit_err  = 1'b0;
                end else if (cls == CLS_S) begin
                    state_nxt = TX_D;
                    emit_err  = 1'b0;
                end
            end
            TX_D: begin
                if (cls == CLS_D) begin
                    state_nxt = TX_D;
                    emit_err  = 1'b0;
                end else if (cls == CLS_T) begin
                    state_nxt = TX_T;
                    emit_err  = 1'b0;
                end
            end
            TX_E: begin
                if (cls == CLS_D) begin
                    state_nxt = TX_D;
                    emit_err  = 1'b0;
                end else if (cls == CLS_C) begin
                    state_nxt = TX_C;
                    emit_err  = 1'b0;
                end else if (cls == CLS_T) begin
                    state_nxt = TX_T;
                    emit_err  = 1'b0;
                end
            end
            default: begin
                state_nxt = TX_E;
                emit_err  = 1'b1;
            end
        endcase
    end

    // Select the outgoing block: error, data or control.
    always_comb begin
        if (emit_err) begin
            block_nxt = ERROR_BLOCK;
        end else if (cls == CLS_D) begin
            block_nxt = {bus.i_txd, 2'b01};
        end else begin
            block_nxt = {ctl_payload, ctl_type, 2'b10};
        end
    end

    // Register state, block and the saturating error counter on each accepted word.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= TX_INIT;
            valid_q <= 1'b0;
            block_q <= IDLE_BLOCK;
            err_cnt <= '0;
        end else begin
            valid_q <= bus.i_valid;
            if (bus.i_valid) begin
                state   <= state_nxt;
                block_q <= block_nxt;
                if (emit_err && err_cnt != {ERR_CNT_W{1'b1}}) begin
                    err_cnt <= err_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.o_valid    = valid_q;
    assign bus.o_tx_block = block_q;
    assign bus.o_err_cnt  = err_cnt;

endmodule

// File: tb/tb_mii_base_r_encoder.sv
// Directed testbench for mii_base_r_encoder: idle, a full frame, illegal
// sequences, gaps, mid-frame reset, terminate boundaries and the lane-4 start.
module tb_mii_base_r_encoder;

    localparam logic [65:0] IDLE_BLK = {56'h0, 8'h1E, 2'b10};
    localparam logic [65:0] ERR_BLK  = {{8{7'h1E}}, 8'h1E, 2'b10};

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   exp_err;

    mii_base_r_encoder_if #(.ERR_CNT_W(16)) bus ();

    mii_base_r_encoder #(.ERR_CNT_W(16)) dut (
        .clk   (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one word at the falling edge, then sample just after the next rising edge.
    task automatic applyStimulus(input logic v, input logic [7:0] c, input logic [63:0] d);
        @(negedge clk);
        bus.i_valid = v;
        bus.i_txc   = c;
        bus.i_txd   = d;
        @(posedge clk);
        #1;
    endtask

    // Check the block and error counter for a valid output cycle.
    task automatic checkBlock(input string tag, input logic [65:0] exp_blk);
        checkOutput({tag, "_valid"}, 66'(bus.o_valid), 66'd1);
        checkOutput({tag, "_blk"}, bus.o_tx_block, exp_blk);
        checkOutput({tag, "_err"}, 66'(bus.o_err_cnt), 66'(exp_err));
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        exp_err     = 0;
        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_txc   = 8'hFF;
        bus.i_txd   = 64'h0707070707070707;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", 66'(bus.o_valid), 66'd0);
        checkOutput("rst_blk", bus.o_tx_block, IDLE_BLK);
        checkOutput("rst_err", 66'(bus.o_err_cnt), 66'd0);
        @(negedge clk);
        rst = 1'b0;

        // Idle stream
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'hFF, 64'h0707070707070707);
            checkBlock("idle", IDLE_BLK);
        end

        // Frame: S, D, gap, T3
        applyStimulus(1'b1, 8'h01, 64'hD5555555555555FB);
        checkBlock("start", {56'hD5555555555555, 8'h78, 2'b10});
        applyStimulus(1'b1, 8'h00, 64'h1122334455667788);
        checkBlock("data", {64'h1122334455667788, 2'b01});
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'h00, 64'hFFFFFFFFFFFFFFFF);
            checkOutput("gap_valid", 66'(bus.o_valid), 66'd0);
            checkOutput("gap_blk", bus.o_tx_block, {64'h1122334455667788, 2'b01});
        end
        applyStimulus(1'b1, 8'hF8, 64'h07070707FDCCBBAA);
        checkBlock("term3", {32'h0, 24'hCCBBAA, 8'hB4, 2'b10});
        applyStimulus(1'b1, 8'hFF, 64'h0707070707070707);
        checkBlock("idle_after_t", IDLE_BLK);

        // Illegal D while idle
        applyStimulus(1'b1, 8'h00, 64'hDEADBEEFCAFEF00D);
        exp_err++;
        checkBlock("illegal_d", ERR_BLK);
        applyStimulus(1'b1, 8'hFF, 64'h0707070707070707);
        checkBlock("recover_idle", IDLE_BLK);

        // Bad idle after FD
        applyStimulus(1'b1, 8'h01, 64'h01020304050607FB);
        checkBlock("start2", {56'h01020304050607, 8'h78, 2'b10});
        applyStimulus(1'b1, 8'hFE, 64'h0707070707070AFD);
        exp_err++;
        checkBlock("bad_idle", ERR_BLK);

        // D is legal out of TX_E
        applyStimulus(1'b1, 8'h00, 64'hA5A5A5A55A5A5A5A);
        checkBlock("d_from_e", {64'hA5A5A5A55A5A5A5A, 2'b01});

        // Asynchronous reset mid-frame, held across an edge with i_valid high
        @(negedge clk);
        rst         = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_txc   = 8'h00;
        bus.i_txd   = 64'h1111111111111111;
        #2;
        checkOutput("async_rst_valid", 66'(bus.o_valid), 66'd0);
        checkOutput("async_rst_err", 66'(bus.o_err_cnt), 66'd0);
        @(posedge clk);
        #1;
        checkOutput("rst_wins_valid", 66'(bus.o_valid), 66'd0);
        checkOutput("rst_wins_blk", bus.o_tx_block, IDLE_BLK);
        @(negedge clk);
        rst         = 1'b0;
        bus.i_valid = 1'b0;
        exp_err     = 0;

        // D out of TX_INIT is illegal
        applyStimulus(1'b1, 8'h00, 64'h1122334455667788);
        exp_err++;
        checkBlock("d_from_init", ERR_BLK);

        // Lane-4 start
        applyStimulus(1'b1, 8'hFF, 64'h07070707070707FE);
        checkBlock("idle_fe", {49'h0, 7'h1E, 8'h1E, 2'b10});
        applyStimulus(1'b1, 8'h1F, 64'h332211FB07070707);
`ifdef LANE4_START_EN
        checkBlock("start4", {24'h332211, 32'h0, 8'h33, 2'b10});
`else
        exp_err++;
        checkBlock("start4", ERR_BLK);
`endif

        // Terminate boundaries: T0 (legal from TX_D or TX_E), then S and T7
        applyStimulus(1'b1, 8'hFF, 64'h07070707070707FD);
        checkBlock("term0", {56'h0, 8'h87, 2'b10});
        applyStimulus(1'b1, 8'h01, 64'h0F0E0D0C0B0A09FB);
        checkBlock("start3", {56'h0F0E0D0C0B0A09, 8'h78, 2'b10});
        applyStimulus(1'b1, 8'h80, 64'hFD77665544332211);
        checkBlock("term7", {56'h77665544332211, 8'hFF, 2'b10});

        // S directly after T is legal; a second S inside the frame is not
        applyStimulus(1'b1, 8'h01, 64'h555555555555AAFB);
        checkBlock("start4b", {56'h555555555555AA, 8'h78, 2'b10});
        applyStimulus(1'b1, 8'h01, 64'h555555555555AAFB);
        exp_err++;
        checkBlock("s_in_frame", ERR_BLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
